// File: rtl/pipe_add_sub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package pipe_add_sub_pkg;

  localparam int MAX_STAGES = 8;

  // Width of one carry-chain segment.
  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_seg.sv
// One carry-chain segment: SEG-bit add with carry in and carry out.
module add_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES segments, one per register stage, with valid/ready on both sides.
// Operands ride along the pipeline so later segments can finish the add;
// B is stored already inverted in subtract mode.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (STAGES > MAX_STAGES) || ((WIDTH % STAGES) != 0)) begin : g_bad_param
    $error("pipe_add_sub: WIDTH must be a multiple of STAGES and STAGES in 1..8");
  end

  // Stage registers
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  // Inputs feeding each stage (primary inputs for stage 0, previous stage otherwise)
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;

  logic [STAGES-1:0][SEG-1:0] seg_sum;
  logic [STAGES-1:0]          seg_co;
  logic [WIDTH-1:0]           s_d [STAGES];
  logic [STAGES:0]            en;

  // Select what each stage would load: stage 0 from the ports, stage k from stage k-1.
  always_comb begin
    a_src[0] = i_a;
    b_src[0] = i_sub ? ~i_b : i_b;
    s_src[0] = '0;
    c_src[0] = i_sub | i_cin;
    v_src[0] = i_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    add_seg #(.SEG(SEG)) u_seg (
      .a_i    (a_src[g][g*SEG +: SEG]),
      .b_i    (b_src[g][g*SEG +: SEG]),
      .cin_i  (c_src[g]),
      .sum_o  (seg_sum[g]),
      .cout_o (seg_co[g])
    );
  end

  // Merge the freshly computed segment into the partial sum carried so far.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = s_src[k];
      s_d[k][k*SEG +: SEG] = seg_sum[k];
    end
  end

  // Advance enables ripple back from the consumer; an empty stage always advances.
  always_comb begin
    en = '0;
    en[STAGES] = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = !v_q[k] | en[k+1];
    end
  end

  // Pipeline registers; a stalled stage holds everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_d[k];
          c_q[k] <= seg_co[k];
          v_q[k] <= v_src[k];
        end
      end
    end
  end

  assign o_ready = en[0];
  assign o_valid = v_q[LAST];
  assign o_sum   = s_q[LAST];
  assign o_cout  = c_q[LAST];
  assign o_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                   (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: directed vectors on 32/2 and 64/4 instances,
// backpressure, mid-stream reset and a short randomized stream.
module tb_pipe_add_sub;

  logic clk;
  logic rst_n;

  logic        v32, ordy32, rdy32, sub32, cin32, ov32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  logic        v64, ordy64, rdy64, sub64, cin64, ov64, cout64, ovf64;
  logic [63:0] a64, b64, sum64;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_add_sub #(.WIDTH(32), .STAGES(2)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(ordy32),
    .i_a(a32), .i_b(b32), .i_sub(sub32), .i_cin(cin32),
    .o_valid(ov32), .i_ready(rdy32), .o_sum(sum32), .o_cout(cout32), .o_ovf(ovf32)
  );

  pipe_add_sub #(.WIDTH(64), .STAGES(4)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v64), .o_ready(ordy64),
    .i_a(a64), .i_b(b64), .i_sub(sub64), .i_cin(cin64),
    .o_valid(ov64), .i_ready(rdy64), .o_sum(sum64), .o_cout(cout64), .o_ovf(ovf64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {ovf, cout, sum} for the 32-bit instance.
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic cin);
    logic [31:0] beff;
    logic [32:0] r;
    logic        ovf;
    beff = sub ? ~b : b;
    r    = {1'b0, a} + {1'b0, beff} + {32'd0, (sub ? 1'b1 : cin)};
    ovf  = (a[31] == beff[31]) && (r[31] != a[31]);
    return {ovf, r};
  endfunction

  task automatic run_op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin,
                          input logic [31:0] es, input logic ec, input logic eo);
    int n;
    @(posedge clk); #1;
    v32 = 1'b1; a32 = a; b32 = b; sub32 = sub; cin32 = cin;
    @(posedge clk); #1;
    v32 = 1'b0;
    n = 1;
    while (!ov32 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".lat"},  n,      2);
    check({tag, ".sum"},  sum32,  es);
    check({tag, ".cout"}, cout32, ec);
    check({tag, ".ovf"},  ovf32,  eo);
    @(posedge clk); #1;
  endtask

  task automatic stream32(input int nops, input bit rnd);
    logic [33:0] q[$];
    logic [33:0] exp;
    int  idx = 0, got = 0, cyc = 0;
    bit  held = 1'b0, saw_full = 1'b0, in_fire, out_fire;
    logic [31:0] held_sum;
    @(posedge clk); #1;
    a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom); cin32 = 1'($urandom);
    v32  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    rdy32 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    while (got < nops && cyc < nops * 20 + 50) begin
      @(negedge clk);
      in_fire  = v32 & ordy32;
      out_fire = ov32 & rdy32;
      if (held) begin
        check("stall.valid", ov32, 1'b1);
        check("stall.sum", sum32, held_sum);
      end
      if (v32 && !ordy32) saw_full = 1'b1;
      if (out_fire) begin
        if (q.size() == 0) check("spurious", ov32, 1'b0);
        else begin
          exp = q.pop_front();
          check("res", {cout32, sum32}, exp[32:0]);
          check("ovf", ovf32, exp[33]);
          got++;
        end
      end
      if (in_fire) begin
        q.push_back(model32(a32, b32, sub32, cin32));
        idx++;
      end
      held     = ov32 & !rdy32;
      held_sum = sum32;
      @(posedge clk); #1;
      cyc++;
      if (in_fire) begin
        a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom); cin32 = 1'($urandom);
      end
      v32   = (idx < nops) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      rdy32 = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc <= 7);
    end
    check("stream.count", got, nops);
    check("stream.leftover", q.size(), 0);
    if (!rnd) check("stream.full_seen", saw_full, 1'b1);
    v32 = 1'b0; rdy32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b0;
    v32 = 1'b1; a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom); cin32 = 1'($urandom);
    rdy32 = 1'($urandom);
    v64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; cin64 = 1'b0; rdy64 = 1'b1;

    // Reset hold with live inputs
    repeat (3) begin
      @(negedge clk);
      check("rst.valid", ov32, 1'b0);
      check("rst.sum", sum32, 32'd0);
      check("rst.cout_ovf", {cout32, ovf32}, 2'b00);
      check("rst.valid64", ov64, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; v32 = 1'b0; rdy32 = 1'b0;
    @(negedge clk);
    check("rst.ready", ordy32, 1'b1);
    @(posedge clk); #1;
    rdy32 = 1'b1;

    // Directed vectors, WIDTH=32 STAGES=2
    run_op32("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op32("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op32("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op32("add_cin",   32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0009, 1'b0, 1'b0);
    run_op32("sub_borrow",32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op32("sub_cin_ig",32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    run_op32("seg_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    // Carry across three segment boundaries, WIDTH=64 STAGES=4
    @(posedge clk); #1;
    v64 = 1'b1; a64 = 64'h0000_FFFF_FFFF_FFFF; b64 = 64'd1; sub64 = 1'b0; cin64 = 1'b0;
    @(posedge clk); #1;
    v64 = 1'b0;
    n = 1;
    while (!ov64 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check("c64.lat", n, 4);
    check("c64.sum", sum64, 64'h0001_0000_0000_0000);
    check("c64.cout_ovf", {cout64, ovf64}, 2'b00);
    @(posedge clk); #1;

    // Backpressure: i_ready low for cycles 3..7
    stream32(10, 1'b0);

    // Reset mid-stream with two ops in flight (one stalled at the output)
    rdy32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b1; a32 = 32'h1111_1111; b32 = 32'h2222_2222; sub32 = 1'b0; cin32 = 1'b0;
    @(posedge clk); #1;
    a32 = 32'h3333_3333; b32 = 32'h4444_4444;
    @(posedge clk); #1;
    v32 = 1'b0;
    check("mid.before_valid", ov32, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid.valid_now", ov32, 1'b0);
    check("mid.sum_now", sum32, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rdy32 = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    check("mid.ghost", seen, 1'b0);

    // Randomized handshake stream against the reference model
    stream32(300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
